// File: rtl/vliw_fwd_scoreboard_pkg.sv
// Shared definitions for the VLIW forwarding scoreboard.
//   - idx_w():      index width for a count of items (clog2, minimum 1)
//   - slot_rec_w(): width of one per-slot record inside a scoreboard entry
//   - FLD_*:        bit layout of a per-slot record {dst, is_load, we}
//   - STAGE_*:      stage encoding; entry k == stage k (EX=0, MEM=1, ...)
package vliw_fwd_scoreboard_pkg;

    localparam int unsigned STAGE_EX  = 0;
    localparam int unsigned STAGE_MEM = 1;

    // Per-slot record layout, LSB first.
    localparam int unsigned FLD_WE  = 0;
    localparam int unsigned FLD_LD  = 1;
    localparam int unsigned FLD_DST = 2;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned slot_rec_w(input int unsigned aw);
        return aw + FLD_DST;
    endfunction

endpackage

// File: rtl/vliw_src_match.sv
// Matches one source operand against the whole scoreboard.
// Ports:
//   used     - source operand is read by the instruction
//   idx      - source register index
//   sb       - flattened scoreboard, entry k at [k*NUM_SLOTS*RW +: NUM_SLOTS*RW]
//   hit      - some in-flight write targets idx
//   stage    - entry of the selected producer (youngest entry wins)
//   slot     - slot of the selected producer (highest slot within that entry)
//   load_hit - selected producer is a load still in EX (load-use hazard)
module vliw_src_match
    import vliw_fwd_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 2,
    parameter int unsigned AW        = 3,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned ZERO_REG  = 0
) (
    input  logic                                       used,
    input  logic [AW-1:0]                              idx,
    input  logic [DEPTH*NUM_SLOTS*slot_rec_w(AW)-1:0]  sb,
    output logic                                       hit,
    output logic [idx_w(DEPTH)-1:0]                    stage,
    output logic [idx_w(NUM_SLOTS)-1:0]                slot,
    output logic                                       load_hit
);

    localparam int unsigned RW  = slot_rec_w(AW);
    localparam int unsigned SW  = idx_w(DEPTH);
    localparam int unsigned SLW = idx_w(NUM_SLOTS);

    logic cand;
    logic sel_ld;

    assign cand = used && ((ZERO_REG == 0) || (idx != '0));

    // Scan oldest-to-youngest and low-to-high slot; the last hit seen is the
    // youngest entry with the highest slot index inside it.
    always_comb begin : p_select
        int unsigned base;
        hit    = 1'b0;
        stage  = '0;
        slot   = '0;
        sel_ld = 1'b0;
        base   = 0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                base = (int'(k) * NUM_SLOTS + s) * RW;
                if (cand && sb[base + FLD_WE] && (sb[base + FLD_DST +: AW] == idx)) begin
                    hit    = 1'b1;
                    stage  = SW'(k);
                    slot   = SLW'(s);
                    sel_ld = sb[base + FLD_LD];
                end
            end
        end
    end

    assign load_hit = hit && sel_ld && (stage == SW'(STAGE_EX));

endmodule

// File: rtl/vliw_fwd_scoreboard.sv
// Forwarding and load-use hazard unit for an NUM_SLOTS-wide VLIW decode stage.
// Tracks in-flight destination writes for DEPTH post-decode stages and
// produces per-source forward selects plus a decode stall.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   issue_*         - decode packet: valid, per-slot we/dst/is_load
//   src_used/idx    - two sources per slot, slot-major
//   flush           - squash the decode packet (wins over stall)
//   stall           - load-use hazard: hold PC and IF/ID, insert a bubble
//   fwd_valid/stage/slot - per-source forward select (0 when no match)
//   pkt_conflict    - sticky: a packet wrote the same register from two slots
//   stall_count     - saturating count of stall cycles
module vliw_fwd_scoreboard
    import vliw_fwd_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 2,
    parameter int unsigned AW        = 3,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned ZERO_REG  = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      issue_valid,
    input  logic [NUM_SLOTS-1:0]                      issue_we,
    input  logic [NUM_SLOTS*AW-1:0]                   issue_dst,
    input  logic [NUM_SLOTS-1:0]                      issue_is_load,
    input  logic [NUM_SLOTS*2-1:0]                    src_used,
    input  logic [NUM_SLOTS*2*AW-1:0]                 src_idx,
    input  logic                                      flush,
    output logic                                      stall,
    output logic [NUM_SLOTS*2-1:0]                    fwd_valid,
    output logic [NUM_SLOTS*2*idx_w(DEPTH)-1:0]       fwd_stage,
    output logic [NUM_SLOTS*2*idx_w(NUM_SLOTS)-1:0]   fwd_slot,
    output logic                                      pkt_conflict,
    output logic [CNT_W-1:0]                          stall_count
);

    localparam int unsigned RW   = slot_rec_w(AW);
    localparam int unsigned EW   = NUM_SLOTS * RW;
    localparam int unsigned SW   = idx_w(DEPTH);
    localparam int unsigned SLW  = idx_w(NUM_SLOTS);
    localparam int unsigned NSRC = NUM_SLOTS * 2;

    logic [DEPTH-1:0][EW-1:0] sb_q, sb_d;
    logic                     pkt_conflict_q, pkt_conflict_d;
    logic [CNT_W-1:0]         stall_count_q, stall_count_d;

    logic [EW-1:0]   pkt;
    logic [NSRC-1:0] load_hit;
    logic            accept;
    logic            dup;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        vliw_src_match #(
            .NUM_SLOTS (NUM_SLOTS),
            .AW        (AW),
            .DEPTH     (DEPTH),
            .ZERO_REG  (ZERO_REG)
        ) u_match (
            .used     (src_used[i]),
            .idx      (src_idx[i*AW +: AW]),
            .sb       (sb_q),
            .hit      (fwd_valid[i]),
            .stage    (fwd_stage[i*SW +: SW]),
            .slot     (fwd_slot[i*SLW +: SLW]),
            .load_hit (load_hit[i])
        );
    end

    assign stall  = issue_valid && !flush && (|load_hit);
    assign accept = issue_valid && !stall && !flush;

    // Pack the decode packet into the scoreboard record layout.
    always_comb begin
        pkt = '0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            pkt[s*RW + FLD_WE]        = issue_we[s];
            pkt[s*RW + FLD_LD]        = issue_is_load[s];
            pkt[s*RW + FLD_DST +: AW] = issue_dst[s*AW +: AW];
        end
    end

    // Two slots of one packet writing the same (non-hardwired) register.
    always_comb begin
        dup = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            for (int unsigned j = i + 1; j < NUM_SLOTS; j++) begin
                if (issue_we[i] && issue_we[j]
                    && (issue_dst[i*AW +: AW] == issue_dst[j*AW +: AW])
                    && ((ZERO_REG == 0) || (issue_dst[i*AW +: AW] != '0))) begin
                    dup = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sb_d[0] = accept ? pkt : '0;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
        pkt_conflict_d = pkt_conflict_q || (accept && dup);
        stall_count_d  = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q           <= '0;
            pkt_conflict_q <= 1'b0;
            stall_count_q  <= '0;
        end else begin
            sb_q           <= sb_d;
            pkt_conflict_q <= pkt_conflict_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign pkt_conflict = pkt_conflict_q;
    assign stall_count  = stall_count_q;

endmodule

// File: doc/vliw_fwd_scoreboard.md
Name: vliw_fwd_scoreboard

Overview:
- Parametrised forwarding and load-use hazard unit for the multi-slot VLIW pipeline; generalises the fixed two-slot ForwardingUnit/HazardDetection pair to NUM_SLOTS issue slots and DEPTH post-decode stages.
- Keeps a shift-register scoreboard of in-flight destination writes and produces per-source forward selects plus a decode stall.
- Sits beside the decode stage. The datapath forwarding muxes consume its selects.

Parameters:
- NUM_SLOTS, 2, issue slots per packet (1..4)
- AW, 3, register index width
- DEPTH, 3, tracked stages after decode (EX=0 .. WB=DEPTH-1), 2..6
- ZERO_REG, 0, 1 = register 0 is hardwired, never matched or stalled
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  decode packet valid
- issue_we  in  NUM_SLOTS  slot writes a register
- issue_dst  in  NUM_SLOTS*AW  destination index per slot
- issue_is_load  in  NUM_SLOTS  slot result comes from data memory
- src_used  in  NUM_SLOTS*2  source operand valid (2 sources per slot)
- src_idx  in  NUM_SLOTS*2*AW  source indices, slot-major
- flush  in  1  squash the decode packet (taken branch/jump/exception)
- stall  out  1  hold PC and the IF/ID latch; insert a bubble
- fwd_valid  out  NUM_SLOTS*2  source is forwarded (0 = use register file)
- fwd_stage  out  NUM_SLOTS*2*max(1,clog2(DEPTH))  producing stage
- fwd_slot  out  NUM_SLOTS*2*max(1,clog2(NUM_SLOTS))  producing slot
- pkt_conflict  out  1  sticky: a packet had two slots writing the same register
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard: DEPTH entries; each holds, per slot, we, dst and is_load. Entry 0 is the packet in EX this cycle.
- On each clock edge, entry k moves to entry k+1 and entry DEPTH-1 retires. Entry 0 loads the decode packet when issue_valid & ~stall & ~flush; otherwise it loads a bubble (all we=0).
- Match for a source: src_used=1 and an entry slot has we=1 with dst==src_idx. With ZERO_REG=1, an index of 0 never matches.
- Select the youngest matching entry (smallest k). Within that entry, the highest slot index wins.
- fwd_valid/fwd_stage/fwd_slot are combinational from the registered scoreboard and current inputs, with zero latency. When nothing matches: fwd_valid=0, fwd_stage=0, fwd_slot=0.
- stall=1 when any used source's selected match is at k=0 with is_load=1 (load-use), and issue_valid=1 and flush=0. The forward outputs for that source still report stage 0; consumers ignore them while stall=1.
- The cycle after a stall, the load is at k=1 and forwarding from stage 1 is legal, so stall deasserts with no further state.
- flush has priority over stall: stall=0 and a bubble is inserted. Older entries are not cleared.
- pkt_conflict: set on an edge where a packet enters entry 0 with two slots having we=1 and the same dst (dst 0 excluded when ZERO_REG=1). Cleared only by reset.
- stall_count: increments on each edge with stall=1 and saturates at all-ones.
- Reset: all entries become bubbles, pkt_conflict=0, stall_count=0. Outputs are then stall=0 and fwd_valid=0.
- Reset during a stall drops the held state, and the next cycle is clean.

Decomposition:
- Shared package holds the slot/stage index width functions (clog2 with min 1), the scoreboard entry field layout, and the stage encoding constants EX=0, MEM=1.
- One natural sub-module, vliw_src_match: a single source matched against the scoreboard, returning hit, stage, slot and load_hit. It is instantiated NUM_SLOTS*2 times.

Test Plan (NUM_SLOTS=2, AW=3, DEPTH=3, ZERO_REG=0):
- ALU chain: issue slot0 write r3; next packet slot1 src0=r3 -> fwd_valid=1, fwd_stage=0, fwd_slot=0, stall=0. Repeat with one bubble between -> stage=1.
- Load-use: issue slot1 load r5; next packet slot0 src1=r5 -> stall=1 for exactly 1 cycle; next cycle fwd_stage=1, fwd_slot=1; stall_count=1.
- Youngest wins: r2 written at entries 2 and 0 (both ALU) -> stage=0. Same-packet double write of r2 -> fwd_slot=1 and pkt_conflict sticks at 1 until reset.
- Flush vs stall: load-use condition with flush=1 -> stall=0; three cycles later the load has retired and r5 sources give fwd_valid=0.
- Saturation: CNT_W=4, 20 back-to-back load-use stalls -> stall_count holds 15.
- Reset mid-stall: assert reset while stall=1 -> next cycle stall=0, fwd_valid=0, pkt_conflict=0, stall_count=0. Repeat with ZERO_REG=1 and dst/src r0 -> never forwards or stalls.
